// File: rtl/sc2110_i2c_arbiter.sv
// sc2110_i2c_arbiter: round-robin sharing of one 16-bit-address I2C master among NUM_REQ requesters with a timeout guard
module sc2110_i2c_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic [NUM_REQ-1:0]    req_exec,
  input  logic [NUM_REQ-1:0]    req_rh_wl,
  input  logic [NUM_REQ*24-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_busy,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  req_err,
  output logic [7:0]            req_rdata,
  output logic                  i2c_exec,
  output logic                  i2c_rh_wl,
  output logic [23:0]           i2c_data,
  input  logic                  i2c_done,
  input  logic                  i2c_ack,
  input  logic [7:0]            i2c_data_r,
  output logic [2:0]            grant_id,
  output logic                  timeout_flag
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d, lat_rw_q, lat_rw_d, elig;
  logic [NUM_REQ-1:0][23:0] lat_data_q, lat_data_d;
  logic [IW-1:0] rr_q, rr_d, g_q, g_d, sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic [7:0] rdata_q, rdata_d;
  logic rw_q, rw_d, err_q, err_d, tof_q, tof_d, grant, tmo;
  assign elig = pending_q & (init_done ? {NUM_REQ{1'b1}} : NUM_REQ'(1));
  assign grant = state_q == IDLE && |elig;
  assign tmo = state_q == WAIT && !i2c_done && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    sel = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[IW'((int'(rr_q) + k) % NUM_REQ)]) sel = IW'((int'(rr_q) + k) % NUM_REQ);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      lat_rw_q   <= '0;
      lat_data_q <= '0;
      rr_q       <= '0;
      g_q        <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      lat_rw_q   <= lat_rw_d;
      lat_data_q <= lat_data_d;
      rr_q       <= rr_d;
      g_q        <= g_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tof_q      <= tof_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (grant ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (i2c_done || tmo ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    pending_d  = pending_q;
    lat_rw_d   = lat_rw_q;
    lat_data_d = lat_data_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_exec[i] && (!pending_q[i] || req_done[i])) begin
        pending_d[i]  = 1'b1;
        lat_rw_d[i]   = req_rh_wl[i];
        lat_data_d[i] = req_data[24*i +: 24];
      end else if (req_done[i]) pending_d[i] = 1'b0;
    g_d     = grant ? sel : g_q;
    data_d  = grant ? lat_data_q[sel] : data_q;
    rw_d    = grant ? lat_rw_q[sel] : rw_q;
    cnt_d   = state_q == WAIT ? cnt_q + CW'(1) : '0;
    rr_d    = state_q == DONE ? (g_q == IW'(NUM_REQ - 1) ? '0 : g_q + IW'(1)) : rr_q;
    rdata_d = state_q == WAIT && i2c_done ? i2c_data_r : tmo ? 8'h00 : rdata_q;
    err_d   = state_q == WAIT && i2c_done ? i2c_ack : tmo ? 1'b1 : err_q;
    tof_d   = tof_q | tmo;
  end
  always_comb begin
    req_busy     = pending_q;
    req_done     = state_q == DONE ? NUM_REQ'(1) << g_q : '0;
    req_err      = err_q;
    req_rdata    = rdata_q;
    i2c_exec     = state_q == ISSUE;
    i2c_rh_wl    = rw_q;
    i2c_data     = data_q;
    grant_id     = 3'(g_q);
    timeout_flag = tof_q;
  end
endmodule
